// File: rtl/rv_fetch.sv
// rtl/rv_fetch.sv - instruction fetch stage with registered-memory issue and 2-entry output queue
//
// Ports:
//   mclk            clock, all state on rising edge
//   rstn            synchronous active-low reset
//   fetch_en        allow new fetches to be issued
//   redirect_valid  one-cycle branch/jump redirect strobe
//   redirect_pc     redirect target byte address (low two bits ignored)
//   PC              fetch address presented to instruction memory
//   instrData       memory read data, valid the cycle after PC was presented
//   if_valid        instruction available to the decoder
//   if_instr        instruction word at queue head (0 when empty)
//   if_pc           byte address of if_instr (0 when empty)
//   id_ready        decoder accepts the head this cycle

module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        mclk,
    input  logic        rstn,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PC,
    input  logic [31:0] instrData,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    logic [31:0] pc_q;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;
    logic [1:0]  count_q;

    // Queue slot 0 is the head, slot 1 the entry behind it.
    logic [31:0] slot_pc_q   [2];
    logic [31:0] slot_instr_q[2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [1:0]  count_after_pop;

    assign if_valid = (count_q != 2'd0);
    assign if_instr = if_valid ? slot_instr_q[0] : 32'h0;
    assign if_pc    = if_valid ? slot_pc_q[0]    : 32'h0;
    assign PC       = pc_q;

    assign pop  = if_valid && id_ready;
    assign push = inflight_q && !redirect_valid;

    // Entries that will need a queue slot once this edge settles: what stays
    // in the queue plus the word returning from memory. A new issue is only
    // allowed if its word is guaranteed a slot next cycle, so the queue can
    // never overflow and no returning word is ever dropped.
    assign occupancy       = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue           = fetch_en && !redirect_valid && (occupancy < 3'd2);
    assign count_after_pop = count_q - {1'b0, pop};

    always_ff @(posedge mclk) begin
        if (!rstn) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_pc_q   <= 32'h0;
            count_q         <= 2'd0;
            slot_pc_q[0]    <= 32'h0;
            slot_pc_q[1]    <= 32'h0;
            slot_instr_q[0] <= 32'h0;
            slot_instr_q[1] <= 32'h0;
        end else if (redirect_valid) begin
            // Redirect wins over everything: drop the in-flight word and all
            // queued words, restart at the word-aligned target.
            pc_q       <= {redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (issue) begin
                inflight_q    <= 1'b1;
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd4;
            end else begin
                // The memory re-reads the held address; that data is never
                // pushed because inflight_q is cleared here.
                inflight_q <= 1'b0;
            end

            if (pop) begin
                slot_pc_q[0]    <= slot_pc_q[1];
                slot_instr_q[0] <= slot_instr_q[1];
            end

            // Push lands in the first free slot after the pop; written after
            // the shift so it overrides slot 0 when the queue drains to empty.
            if (push) begin
                if (count_after_pop == 2'd0) begin
                    slot_pc_q[0]    <= inflight_pc_q;
                    slot_instr_q[0] <= instrData;
                end else begin
                    slot_pc_q[1]    <= inflight_pc_q;
                    slot_instr_q[1] <= instrData;
                end
            end

            count_q <= count_after_pop + {1'b0, push};
        end
    end

endmodule

// File: tb/tb_rv_fetch.sv
// tb/tb_rv_fetch.sv - directed self-checking bench for rv_fetch

module tb_rv_fetch;

    logic        mclk;
    logic        rstn;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic [31:0] PC;
    logic [31:0] instrData;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic [31:0] PC_w;
    logic [31:0] instrData_w;
    logic        if_valid_w;
    logic [31:0] if_instr_w;
    logic [31:0] if_pc_w;

    int n_assert;
    int n_fail;

    rv_fetch dut (
        .mclk           (mclk),
        .rstn           (rstn),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .PC             (PC),
        .instrData      (instrData),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    rv_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .mclk           (mclk),
        .rstn           (rstn),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .PC             (PC_w),
        .instrData      (instrData_w),
        .if_valid       (if_valid_w),
        .if_instr       (if_instr_w),
        .if_pc          (if_pc_w),
        .id_ready       (id_ready)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Registered instruction memory: word at byte address a is 0x1000_0000 + a/4.
    always @(posedge mclk) begin
        instrData   <= 32'h1000_0000 + {2'b00, PC[31:2]};
        instrData_w <= 32'h1000_0000 + {2'b00, PC_w[31:2]};
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic reset_dut();
        rstn           = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        rstn = 1'b0;
        fetch_en = 1'b1;
        tick();
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %0b exp 0", if_valid); end
        n_assert++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr got %h exp 0", if_instr); end
        n_assert++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc got %h exp 0", if_pc); end
        n_assert++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_PC got %h exp 0", PC); end
        n_assert++; if (PC_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_PC_w got %h exp fffffff8", PC_w); end
        rstn = 1'b1;
    endtask

    // Reset release with fetch_en and id_ready high: one word per cycle from edge 2.
    task automatic test_stream();
        reset_dut();
        fetch_en = 1'b1;
        id_ready = 1'b1;
        tick();
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_edge1_valid got %0b exp 0", if_valid); end
        n_assert++; if (PC !== 32'h4) begin n_fail++; $display("FAIL stream_edge1_PC got %h exp 4", PC); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_assert++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, if_valid); end
            n_assert++; if (if_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, if_pc, 32'(4 * i)); end
            n_assert++; if (if_instr !== 32'h1000_0000 + 32'(i)) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, if_instr, 32'h1000_0000 + 32'(i)); end
        end
    endtask

    // Decoder stall: head held, queue fills, issue stops at PC=8, then resumes without gaps.
    task automatic test_stall();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        reset_dut();
        fetch_en = 1'b1;
        id_ready = 1'b1;
        tick();
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=10000000", i, if_valid, if_pc, if_instr);
            end
            n_assert++; if (PC !== 32'h8) begin n_fail++; $display("FAIL stall_PC[%0d] got %h exp 8", i, PC); end
        end
        n_assert++; if (dut.count_q !== 2'd2) begin n_fail++; $display("FAIL stall_count got %0d exp 2", dut.count_q); end
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_assert++; if (if_valid !== 1'b1 || if_pc !== exp_pc[i]) begin
                n_fail++; $display("FAIL stall_resume[%0d] got v=%0b pc=%h exp v=1 pc=%h", i, if_valid, if_pc, exp_pc[i]);
            end
        end
    endtask

    // Redirect while a word is queued and another is in flight.
    task automatic test_redirect();
        reset_dut();
        fetch_en = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_assert++; if (!(dut.inflight_q === 1'b1 && dut.count_q === 2'd1)) begin
            n_fail++; $display("FAIL redirect_precond got inflight=%0b count=%0d exp 1/1", dut.inflight_q, dut.count_q);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_flush_valid got %0b exp 0", if_valid); end
        n_assert++; if (PC !== 32'h100) begin n_fail++; $display("FAIL redirect_PC got %h exp 100", PC); end
        tick();
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_no_stale got v=%0b pc=%h exp v=0", if_valid, if_pc); end
        tick();
        n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h1000_0040) begin
            n_fail++; $display("FAIL redirect_target got v=%0b pc=%h instr=%h exp v=1 pc=100 instr=10000040", if_valid, if_pc, if_instr);
        end
        tick();
        n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin
            n_fail++; $display("FAIL redirect_next got v=%0b pc=%h exp v=1 pc=104", if_valid, if_pc);
        end
    endtask

    // Address wrap from 0xFFFF_FFF8 on the second instance.
    task automatic test_wrap();
        logic [31:0] exp_pc    [3];
        logic [31:0] exp_instr [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_instr[0] = 32'h4FFF_FFFE;
        exp_pc[1] = 32'hFFFF_FFFC; exp_instr[1] = 32'h4FFF_FFFF;
        exp_pc[2] = 32'h0000_0000; exp_instr[2] = 32'h1000_0000;
        reset_dut();
        fetch_en = 1'b1;
        id_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_assert++; if (if_valid_w !== 1'b1 || if_pc_w !== exp_pc[i] || if_instr_w !== exp_instr[i]) begin
                n_fail++; $display("FAIL wrap[%0d] got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h", i, if_valid_w, if_pc_w, if_instr_w, exp_pc[i], exp_instr[i]);
            end
        end
    endtask

    // fetch_en dropped right after the first issue: in-flight word still arrives.
    task automatic test_fetch_en();
        reset_dut();
        fetch_en = 1'b1;
        id_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL fen_inflight got v=%0b pc=%h exp v=1 pc=0", if_valid, if_pc);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_assert++; if (if_valid !== 1'b0 || PC !== 32'h4) begin
                n_fail++; $display("FAIL fen_idle[%0d] got v=%0b PC=%h exp v=0 PC=4", i, if_valid, PC);
            end
        end
        fetch_en = 1'b1;
        tick();
        tick();
        n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
            n_fail++; $display("FAIL fen_resume got v=%0b pc=%h exp v=1 pc=4", if_valid, if_pc);
        end
    endtask

    // One-edge reset with a full queue and a coincident redirect.
    task automatic test_reset_mid();
        reset_dut();
        fetch_en = 1'b1;
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_assert++; if (dut.count_q !== 2'd2) begin n_fail++; $display("FAIL rmid_precond got count=%0d exp 2", dut.count_q); end
        rstn           = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        n_assert++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || PC !== 32'h0) begin
            n_fail++; $display("FAIL rmid_outputs got v=%0b instr=%h pc=%h PC=%h exp all 0", if_valid, if_instr, if_pc, PC);
        end
        rstn           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        tick();
        tick();
        n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL rmid_restart got v=%0b pc=%h exp v=1 pc=0", if_valid, if_pc);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_fetch_en();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
